// File: rtl/or_tree_pipe.sv
// or_tree_pipe: pipelined bitwise OR-reduction of NUM_IN lanes with valid tracking
//   and optional sticky error accumulation.
//   Optional feature macro: OR_TREE_STICKY_EN (sticky_y/hit_cnt logic built when defined).
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears pipeline and sticky state
//   in_valid   in_data valid this cycle
//   in_data    NUM_IN lanes, lane k = in_data[k*WIDTH +: WIDTH]
//   sticky_clr clear sticky_y/hit_cnt (same-cycle valid result folded in after the clear)
//   out_valid  out_y valid, PIPE_STAGES cycles after the sampled word
//   out_y      OR of all lanes of the sampled word
//   sticky_y   accumulated OR of valid out_y since last clear
//   hit_cnt    saturating count of valid nonzero results
module or_tree_pipe #(
    parameter int NUM_IN      = 8,
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    sticky_clr,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_y,
    output logic [WIDTH-1:0]        sticky_y,
    output logic [CNT_W-1:0]        hit_cnt
);
    localparam int LVL = $clog2(NUM_IN);
    localparam int P   = 1 << LVL;

    // Tree levels completed after s register stages; leftover levels go to the earliest stages.
    function automatic int levels_done(input int s);
        return s * (LVL / PIPE_STAGES) + ((s < LVL % PIPE_STAGES) ? s : LVL % PIPE_STAGES);
    endfunction

    // Missing lanes of a non-power-of-two tree are zero, which is neutral for OR.
    logic [P*WIDTH-1:0] pad;
    assign pad = (P*WIDTH)'(in_data);

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_st
        localparam int NI = P >> levels_done(s);
        localparam int NO = P >> levels_done(s + 1);
        localparam int G  = NI / NO;
        logic [NI*WIDTH-1:0] d;
        logic [NO*WIDTH-1:0] r;
        logic [NO*WIDTH-1:0] q;
        logic                vi;
        logic                v;
        if (s == 0) begin : g_in
            assign d  = pad;
            assign vi = in_valid;
        end else begin : g_mid
            assign d  = g_st[s-1].q;
            assign vi = g_st[s-1].v;
        end
        // Several adjacent tree levels collapse into one OR over groups of G consecutive lanes.
        always_comb begin
            r = '0;
            for (int j = 0; j < NO; j++)
                for (int k = 0; k < G; k++)
                    r[j*WIDTH +: WIDTH] = r[j*WIDTH +: WIDTH] | d[(j*G+k)*WIDTH +: WIDTH];
        end
        // Data loads every cycle regardless of valid; only the valid bit marks bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                q <= r;
                v <= vi;
            end
        end
    end

    assign out_y     = g_st[PIPE_STAGES-1].q;
    assign out_valid = g_st[PIPE_STAGES-1].v;

`ifdef OR_TREE_STICKY_EN
    logic [WIDTH-1:0] sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;
    assign hit = out_valid && (|out_y);
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
            cnt_q    <= '0;
        end else if (sticky_clr) begin
            sticky_q <= out_valid ? out_y : '0;
            cnt_q    <= CNT_W'(hit);
        end else if (out_valid) begin
            sticky_q <= sticky_q | out_y;
            cnt_q    <= (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end
    end
    assign sticky_y = sticky_q;
    assign hit_cnt  = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = sticky_clr;
    assign sticky_y   = '0;
    assign hit_cnt    = '0;
`endif

endmodule

// File: tb/tb_or_tree_pipe.sv
// tb_or_tree_pipe: randomized self-checking bench for or_tree_pipe against a lane-OR/latency model,
//   driving three configurations (8x4 bits/2 stages, 5x1 bit/3 stages/CNT_W=2, 8x1 bit/1 stage).
module tb_or_tree_pipe;
`ifdef OR_TREE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic sticky_clr = 1'b0;
    logic [31:0] da = '0;
    logic [4:0]  db = '0;
    logic [7:0]  dc = '0;

    logic va, vb, vc;
    logic [3:0]  ya, sa;
    logic [0:0]  yb, sb, yc, sc;
    logic [15:0] ca;
    logic [1:0]  cb;
    logic [3:0]  cc;

    int errors = 0;
    int checks = 0;

    int st[3]  = '{2, 3, 1};
    int nin[3] = '{8, 5, 8};
    int wd[3]  = '{4, 1, 1};
    int cw[3]  = '{16, 2, 4};

    // Model: a word's OR result and valid emerge st[d] samples later; sticky/count from the rules.
    int pv[3][4];
    int py[3][4];
    int es[3];
    int ec[3];

    or_tree_pipe #(.NUM_IN(8), .WIDTH(4), .PIPE_STAGES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(da), .sticky_clr(sticky_clr),
        .out_valid(va), .out_y(ya), .sticky_y(sa), .hit_cnt(ca));
    or_tree_pipe #(.NUM_IN(5), .WIDTH(1), .PIPE_STAGES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(db), .sticky_clr(sticky_clr),
        .out_valid(vb), .out_y(yb), .sticky_y(sb), .hit_cnt(cb));
    or_tree_pipe #(.NUM_IN(8), .WIDTH(1), .PIPE_STAGES(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(dc), .sticky_clr(sticky_clr),
        .out_valid(vc), .out_y(yc), .sticky_y(sc), .hit_cnt(cc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lane_or(input int unsigned w, input int n, input int width);
        int r = 0;
        for (int k = 0; k < n; k++) r |= int'((w >> (k * width)) & ((32'd1 << width) - 1));
        return r;
    endfunction

    task automatic model_edge(input int d, input bit r, input bit v, input bit c, input int unsigned w);
        int ov, oy;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                pv[d][i] = 0;
                py[d][i] = 0;
            end
            es[d] = 0;
            ec[d] = 0;
        end else begin
            ov = pv[d][st[d]-1];
            oy = py[d][st[d]-1];
            if (c) begin
                es[d] = ov != 0 ? oy : 0;
                ec[d] = (ov != 0 && oy != 0) ? 1 : 0;
            end else if (ov != 0) begin
                es[d] |= oy;
                if (oy != 0 && ec[d] < (1 << cw[d]) - 1) ec[d]++;
            end
            for (int i = 3; i > 0; i--) begin
                pv[d][i] = pv[d][i-1];
                py[d][i] = py[d][i-1];
            end
            pv[d][0] = v ? 1 : 0;
            py[d][0] = lane_or(w, nin[d], wd[d]);
        end
    endtask

    task automatic compare(input int d, input bit r);
        int gv, gy, gs, gc;
        gv = d == 0 ? int'(va) : d == 1 ? int'(vb) : int'(vc);
        gy = d == 0 ? int'(ya) : d == 1 ? int'(yb) : int'(yc);
        gs = d == 0 ? int'(sa) : d == 1 ? int'(sb) : int'(sc);
        gc = d == 0 ? int'(ca) : d == 1 ? int'(cb) : int'(cc);
        check($sformatf("out_valid[%0d]", d), gv, pv[d][st[d]-1]);
        if (r || pv[d][st[d]-1] != 0) check($sformatf("out_y[%0d]", d), gy, py[d][st[d]-1]);
        check($sformatf("sticky_y[%0d]", d), gs, STICKY ? es[d] : 0);
        check($sformatf("hit_cnt[%0d]", d), gc, STICKY ? ec[d] : 0);
    endtask

    task automatic step(input bit v, input bit c, input bit r,
                        input logic [31:0] a, input logic [4:0] b, input logic [7:0] w);
        in_valid = v;
        sticky_clr = c;
        rst = r;
        da = a;
        db = b;
        dc = w;
        @(posedge clk);
        model_edge(0, r, v, c, a);
        model_edge(1, r, v, c, 32'(b));
        model_edge(2, r, v, c, 32'(w));
        #1;
        for (int d = 0; d < 3; d++) compare(d, r);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'h1F, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'h1F, 8'hFF);
        // Zero word then a single hot lane.
        step(1'b1, 1'b0, 1'b0, 32'h0, 5'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h0001_0000, 5'h10, 8'h10);
        flush(3);
        // Walking one across every lane.
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b0, 1'b0, 32'h5 << (4 * k), 5'(1 << (k % 5)), 8'(1 << k));
        step(1'b1, 1'b0, 1'b0, 32'h0, 5'h00, 8'h00);
        flush(3);
        // Bubble pattern 1,0,1,1.
        step(1'b1, 1'b0, 1'b0, $urandom, 5'($urandom), 8'($urandom));
        step(1'b0, 1'b0, 1'b0, $urandom, 5'($urandom), 8'($urandom));
        step(1'b1, 1'b0, 1'b0, $urandom, 5'($urandom), 8'($urandom));
        step(1'b1, 1'b0, 1'b0, $urandom, 5'($urandom), 8'($urandom));
        flush(3);
        // Sticky: results 1,0,8 then a clear coinciding with a result of 2.
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 32'h0000_0001, 5'h01, 8'h01);
        step(1'b1, 1'b0, 1'b0, 32'h0, 5'h00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h8000_0000, 5'h04, 8'h80);
        flush(3);
        step(1'b1, 1'b0, 1'b0, 32'h0000_2000, 5'h02, 8'h02);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);
        flush(3);
        // Saturation: five nonzero results.
        step(1'b0, 1'b1, 1'b0, '0, '0, '0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h1 << k, 5'(1 << k), 8'(1 << k));
        flush(4);
        // Reset with words in flight.
        step(1'b1, 1'b0, 1'b0, 32'h1111_1111, 5'h1F, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 32'h2222_2222, 5'h1F, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 32'h4444_4444, 5'h1F, 8'hFF);
        flush(4);
        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'h1 << $urandom_range(0, 31),
                 ($urandom_range(0, 2) != 0) ? 5'h00 : 5'($urandom),
                 ($urandom_range(0, 2) != 0) ? 8'h00 : 8'($urandom));
        flush(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
